// File: rtl/state_sequencer.sv
// state_sequencer: multi-cycle instruction control FSM.
// It tracks the current instruction phase and counts instructions that complete.
module state_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  opcode,
    input  logic [5:0]  func_code,
    input  logic        bcond,
    input  logic        mem_ready,
    output logic [4:0]  state,
    output logic        inst_done,
    output logic [15:0] num_inst,
    output logic        is_halted
);
    typedef enum logic [4:0] {
        S_RESET   = 5'd0,
        S_IF      = 5'd1,
        S_ID      = 5'd2,
        S_EX_R    = 5'd8,
        S_EX_I    = 5'd9,
        S_EX_ADDR = 5'd10,
        S_EX_BR   = 5'd11,
        S_BR_TKN  = 5'd12,
        S_MEM_RD  = 5'd14,
        S_MEM_WR  = 5'd15,
        S_WB_MEM  = 5'd17,
        S_WB_ALU  = 5'd18,
        S_WB_LINK = 5'd19,
        S_HALT    = 5'd20
    } state_t;

    state_t      state_q, state_d;
    logic        inst_done_q, inst_done_d;
    logic [15:0] num_inst_q, num_inst_d;
    logic        done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_RESET;
            inst_done_q <= 1'b0;
            num_inst_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            inst_done_q <= inst_done_d;
            num_inst_q  <= num_inst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            S_RESET: state_d = S_IF;
            S_IF:    state_d = mem_ready ? S_ID : S_IF;
            S_ID: begin
                if (opcode == 4'd15 && func_code <= 6'd7) state_d = S_EX_R;
                else if (opcode >= 4'd4 && opcode <= 4'd6) state_d = S_EX_I;
                else if (opcode == 4'd7 || opcode == 4'd8) state_d = S_EX_ADDR;
                else if (opcode <= 4'd3) state_d = S_EX_BR;
                else if (opcode == 4'd10 || (opcode == 4'd15 && func_code == 6'd26)) state_d = S_WB_LINK;
                else if (opcode == 4'd15 && func_code == 6'd29) begin
                    state_d = S_HALT;
                    done    = 1'b1;
                end else begin
                    // JMP, JPR, WWD and every undecoded encoding retire directly
                    state_d = S_IF;
                    done    = 1'b1;
                end
            end
            S_EX_R, S_EX_I: state_d = S_WB_ALU;
            // a non-memory opcode here is abandoned without being counted
            S_EX_ADDR: state_d = (opcode == 4'd7) ? S_MEM_RD : (opcode == 4'd8) ? S_MEM_WR : S_IF;
            S_EX_BR: begin
                state_d = bcond ? S_BR_TKN : S_IF;
                done    = !bcond;
            end
            S_MEM_RD: state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR: begin
                state_d = mem_ready ? S_IF : S_MEM_WR;
                done    = mem_ready;
            end
            S_BR_TKN, S_WB_ALU, S_WB_MEM, S_WB_LINK: begin
                state_d = S_IF;
                done    = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
        inst_done_d = done;
        num_inst_d  = num_inst_q + {15'd0, done};
    end

    assign state     = state_q;
    assign inst_done = inst_done_q;
    assign num_inst  = num_inst_q;
    assign is_halted = (state_q == S_HALT);
endmodule

// File: doc/state_sequencer.md
STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 clk  input  1  single system clock; all state updates occur on its rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 opcode  input  4  opcode field of the instruction register; valid from ID onward.
REQ-004 func_code  input  6  function field of the instruction register; used only when opcode=15.
REQ-005 bcond  input  1  branch condition from the ALU; sampled only in EX_BR.
REQ-006 mem_ready  input  1  memory access complete; sampled only in IF, MEM_RD and MEM_WR.
REQ-007 state  output  5  current state code, registered; drives the control-signal decoder.
REQ-008 inst_done  output  1  one-cycle pulse marking instruction completion, registered.
REQ-009 num_inst  output  16  count of completed instructions, registered.
REQ-010 is_halted  output  1  high while in HALT.
REQ-011 State codes are RESET=0, IF=1, ID=2, EX_R=8, EX_I=9, EX_ADDR=10, EX_BR=11, BR_TAKEN=12, MEM_RD=14, MEM_WR=15, WB_MEM=17, WB_ALU=18, WB_LINK=19, HALT=20.

Function
REQ-012 Exactly one state transition, or none, occurs per rising clk edge.
REQ-013 RESET transitions unconditionally to IF.
REQ-014 IF holds while mem_ready=0 and goes to ID on mem_ready=1.
REQ-015 ID decode for ALU-type operations:
- opcode 15 with func_code 0-7 -> EX_R.
- opcode 4/5/6 (ADI/ORI/LHI) -> EX_I.
- opcode 7/8 (LWD/SWD) -> EX_ADDR.
- opcode 0-3 (BNE/BEQ/BGZ/BLZ) -> EX_BR.
REQ-016 ID decode for jumps and special operations:
- opcode 9 (JMP) -> IF, completing.
- opcode 10 (JAL) -> WB_LINK.
- opcode 15 func 25 (JPR) -> IF, completing.
- opcode 15 func 26 (JRL) -> WB_LINK.
- opcode 15 func 28 (WWD) -> IF, completing.
- opcode 15 func 29 (HLT) -> HALT, completing.
- any other encoding -> IF, completing (treated as NOP).
REQ-017 EX_R and EX_I go to WB_ALU.
REQ-018 EX_ADDR goes to MEM_RD when opcode=7 and to MEM_WR when opcode=8.
REQ-019 EX_BR goes to BR_TAKEN when bcond=1, and to IF (completing) when bcond=0.
REQ-020 BR_TAKEN goes to IF, completing.
REQ-021 MEM_RD holds while mem_ready=0 and goes to WB_MEM on mem_ready=1.
REQ-022 MEM_WR holds while mem_ready=0 and goes to IF (completing) on mem_ready=1.
REQ-023 WB_ALU, WB_MEM and WB_LINK go to IF, completing.
REQ-024 HALT is absorbing: it is exited only by reset_n=0.
REQ-025 An unused state code goes to IF, non-completing.
REQ-026 On each completing transition, on the same edge:
- num_inst increments by 1, wrapping 16'hFFFF -> 16'h0000.
- inst_done is high for exactly the next cycle.
REQ-027 inst_done is 0 in every cycle not immediately following a completing transition.
REQ-028 Back-to-back completions produce inst_done high on consecutive completion cycles, with no pulse merging lost from num_inst.
REQ-029 is_halted = 1 exactly when state=HALT.
REQ-030 mem_ready is ignored in every state other than IF, MEM_RD and MEM_WR.
REQ-031 opcode and func_code are ignored outside ID and EX_ADDR.
REQ-032 Minimum latencies in cycles, measured from IF entry back to IF entry, with mem_ready=1 throughout:
- R-type / I-type: 4.
- LWD: 5.
- SWD: 4.
- taken branch: 4.
- untaken branch: 3.
- JMP / JPR / WWD: 2.
- JAL / JRL: 3.

Reset
REQ-033 reset_n=0 immediately, without waiting for clk, forces state=RESET, num_inst=0, inst_done=0 and is_halted=0.
REQ-034 Reset asserted mid-instruction, including during a memory wait, abandons that instruction without counting it.
REQ-035 After reset_n rises, the first clk edge moves RESET -> IF.

Verification
REQ-036 Scenario: reset release, then ADD (op15, func0) with mem_ready=1.
- Required state sequence: 0,1,2,8,18,1.
- Required result: inst_done pulses once; num_inst=1.
REQ-037 Scenario: LWD (op7) with mem_ready low for 3 cycles in IF and 2 cycles in MEM_RD.
- Required state sequence: IF held 4 cycles, then 2,10, MEM_RD held 3 cycles, then 17,1.
- Required result: num_inst increments by exactly 1.
REQ-038 Scenario: BEQ with bcond=1, then BNE with bcond=0.
- Required state sequences: 1,2,11,12,1 for BEQ; 1,2,11,1 for BNE.
- Required result: num_inst +2.
REQ-039 Scenario: HLT (op15, func29).
- Required response: state=20, is_halted=1, num_inst +1.
- Required response: state held for 10 cycles regardless of the opcode and mem_ready inputs.
REQ-040 Scenario: num_inst preset to 16'hFFFF via 65535 JMPs, then one more JMP.
- Required result: num_inst=0 and inst_done=1.
REQ-041 Scenario: reset_n pulsed low mid-cycle during the MEM_WR wait.
- Required response: state=0, num_inst=0 and inst_done=0 immediately, with no clk edge needed.
- Required response: IF on the first edge after release.
